// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA decryption datapath blocks that share the
// single divider: arbiter state encoding and the default operand width.
package rsa_pkg;

  localparam int RSA_WIDTH = 2048;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/div_share_arbiter_rr_pick.sv
// Round-robin priority picker: first set request at or after ptr, wrapping,
// returned both one-hot and as an index.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   idx,
  output logic            any
);

  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    any   = |req;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j]) begin
        grant[j] = 1'b1;
        idx      = PW'(j);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_share_arbiter.sv
// Shares one divider between NREQ requesters: round-robin grant, operand
// capture, one division in flight, result routed back with a one-hot valid.
module div_share_arbiter
  import rsa_pkg::*;
#(
  parameter int WIDTH   = RSA_WIDTH,
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 4200
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_q,
  input  logic [NREQ*WIDTH-1:0] req_m,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_quot,
  output logic [WIDTH-1:0]      rsp_rem,
  output logic                  rsp_err,
  output logic                  div_start,
  output logic [WIDTH-1:0]      div_q,
  output logic [WIDTH-1:0]      div_m,
  input  logic [WIDTH-1:0]      div_qout,
  input  logic [WIDTH-1:0]      div_r,
  input  logic                  div_done,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  // Handshake: a requester holds req[i] and its operands until it sees ack[i]
  // (one cycle, operands already captured); rsp_valid[i] later pulses once with
  // rsp_quot/rsp_rem/rsp_err valid in that cycle. No backpressure on responses.

  arb_state_e        state_q, state_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]  rsp_quot_q, rsp_quot_d;
  logic [WIDTH-1:0]  rsp_rem_q, rsp_rem_d;
  logic              rsp_err_q, rsp_err_d;
  logic              div_start_q, div_start_d;
  logic [WIDTH-1:0]  div_q_q, div_q_d;
  logic [WIDTH-1:0]  div_m_q, div_m_d;
  logic [WDW-1:0]    wd_cnt_q, wd_cnt_d;
  logic              first_wait_q, first_wait_d;

  logic [NREQ-1:0]   pick_grant;
  logic [PW-1:0]     pick_idx;
  logic              pick_any;
  logic [WIDTH-1:0]  sel_q, sel_m;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req   (req),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign sel_q = req_q[pick_idx*WIDTH +: WIDTH];
  assign sel_m = req_m[pick_idx*WIDTH +: WIDTH];

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    ack_d        = '0;
    rsp_valid_d  = '0;
    rsp_quot_d   = rsp_quot_q;
    rsp_rem_d    = rsp_rem_q;
    rsp_err_d    = rsp_err_q;
    div_start_d  = 1'b0;
    div_q_d      = div_q_q;
    div_m_d      = div_m_q;
    wd_cnt_d     = wd_cnt_q;
    first_wait_d = first_wait_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d  = pick_grant;
          ack_d    = pick_grant;
          rr_ptr_d = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);
          div_q_d  = sel_q;
          div_m_d  = sel_m;
          if (sel_m == '0) begin
            // Divide-by-zero is answered locally; the divider is never started.
            rsp_quot_d = '1;
            rsp_rem_d  = sel_q;
            rsp_err_d  = 1'b1;
            state_d    = ST_RESP;
          end else begin
            div_start_d = 1'b1;
            state_d     = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        wd_cnt_d     = '0;
        first_wait_d = 1'b1;
        state_d      = ST_WAIT;
      end
      ST_WAIT: begin
        first_wait_d = 1'b0;
        // A done level on the first WAIT cycle is left over from the previous op.
        if (!first_wait_q && div_done) begin
          rsp_quot_d = div_qout;
          rsp_rem_d  = div_r;
          rsp_err_d  = 1'b0;
          state_d    = ST_RESP;
        end else if (TIMEOUT != 0 && wd_cnt_q == WDW'(TIMEOUT - 1)) begin
          rsp_quot_d = '0;
          rsp_rem_d  = '0;
          rsp_err_d  = 1'b1;
          state_d    = ST_RESP;
        end else if (TIMEOUT != 0) begin
          wd_cnt_d = wd_cnt_q + WDW'(1);
        end
      end
      ST_RESP: begin
        rsp_valid_d = grant_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      ack_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_quot_q   <= '0;
      rsp_rem_q    <= '0;
      rsp_err_q    <= 1'b0;
      div_start_q  <= 1'b0;
      div_q_q      <= '0;
      div_m_q      <= '0;
      wd_cnt_q     <= '0;
      first_wait_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      ack_q        <= ack_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_quot_q   <= rsp_quot_d;
      rsp_rem_q    <= rsp_rem_d;
      rsp_err_q    <= rsp_err_d;
      div_start_q  <= div_start_d;
      div_q_q      <= div_q_d;
      div_m_q      <= div_m_d;
      wd_cnt_q     <= wd_cnt_d;
      first_wait_q <= first_wait_d;
    end
  end

  assign ack       = ack_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_quot  = rsp_quot_q;
  assign rsp_rem   = rsp_rem_q;
  assign rsp_err   = rsp_err_q;
  assign div_start = div_start_q;
  assign div_q     = div_q_q;
  assign div_m     = div_m_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule
